balance_cntrl: RTL and testbench
================================

// Module: balance_cntrl
// PURPOSE
//  Consumes fusion-corrected pitch (ptch/vld) from inert_intf and closes the balance loop.
//  Contains a PID on pitch error with a saturating, overflow-frozen integrator and a vld-qualified derivative queue.
//  Adds steering torque, applies soft-start and rider-off gating, and drives the motor drive stage.
//  Motor commands are sign/magnitude speed plus direction.
// PARAMETERS
//  P_COEFF      12    signed P gain (5b) applied to saturated pitch error
//  D_COEFF      20    signed D gain (7b) applied to saturated pitch-error difference
//  D_DEPTH      2     derivative queue depth in vld samples (>=1)
//  TOO_FAST     1536  |torque| threshold for too_fast flag
// PORTS
//  clk           in   1   50MHz system clock
//  rst_n         in   1   asynchronous active-low reset
//  vld           in   1   1-cycle strobe: new ptch sample valid
//  ptch          in   16  signed pitch from inert_intf
//  ld_cell_diff  in   12  signed left-minus-right load cell difference (steering)
//  en_steer      in   1   1: add steering term; 0: steer term = 0
//  rider_off     in   1   1: clear integrator, force outputs to 0, FSM->IDLE
//  pwr_up        in   1   level; 0 forces IDLE
//  lft_spd       out  11  left motor magnitude (0..2047)
//  lft_rev       out  1   left motor reverse
//  rght_spd      out  11  right motor magnitude
//  rght_rev      out  1   right motor reverse
//  too_fast      out  1   registered; |lft_trq| or |rght_trq| > TOO_FAST
// BEHAVIOUR
//  Reset: all outputs 0, integrator 0, D queue 0, PID reg 0, FSM IDLE, ramp_cnt 0.
//  Error path (comb):
//   - err_sat = ptch saturated to signed 10b [-512,511].
//   - P = err_sat*P_COEFF, 15b signed.
//  Integrator (18b signed), updated only on vld & ~rider_off:
//   - sum = integ + sext(err_sat).
//   - Operand signs equal and sum sign differs -> hold (no wrap).
//   - I = integ>>>6, sign-extended to 16b.
//  Derivative:
//   - On vld, queue shifts in err_sat; oldest entry = err from D_DEPTH vlds ago.
//   - diff = err_sat - oldest, saturated to signed 7b [-64,63].
//   - D = diff*D_COEFF, 13b signed.
//  PID:
//   - PID = sext16(P)+I+sext16(D), saturated to 16b.
//   - Registered on vld; latency vld->pid_reg = 1 clk; outputs 1 clk later (2 total).
//  Steering:
//   - steer = en_steer ? sext16(ld_cell_diff>>>3) : 0.
//   - lft_trq = pid_reg+steer; rght_trq = pid_reg-steer (17b, no wrap).
//  Output: rev = sign(trq); spd = min(|trq|, limit); limit = RUN ? 2047 : ramp_cnt.
//  FSM (IDLE/RAMP/RUN):
//   - IDLE: outputs 0, ramp_cnt 0; pwr_up & ~rider_off -> RAMP.
//   - RAMP: ramp_cnt += 1 per clk; ramp_cnt==2047 -> RUN.
//   - RUN: full range.
//   - Any state: ~pwr_up or rider_off -> IDLE next clk.
//   - rider_off wins over pwr_up.
//  too_fast: evaluated on unsaturated trq every clk; 0 in IDLE.
//  Simultaneous vld & rider_off: integrator cleared, queue still shifts, pid_reg updates.
//  Mid-operation reset returns every register to its reset value immediately.
// STRUCTURE
//  segway_pkg:
//   - bal_state_t enum {IDLE,RAMP,RUN}.
//   - Saturation widths (ERR_W=10, DIFF_W=7, INTEG_W=18).
//   - sat_signed() function.
//  Sub-module balance_pid: err sat, integrator, D queue, pid_reg; outputs pid_reg.
//  Top: steering, FSM/ramp, sign-magnitude output, too_fast.
// TESTING
//  1. RUN, en_steer=0, fresh state, one vld with ptch=16'h0010.
//     -> P=192, I=0, D=320; lft_spd=rght_spd=512, rev=0, 2 clks after vld.
//  2. RUN, ptch=16'h8000 held over vlds.
//     -> err_sat=-512; lft_spd=2047, lft_rev=1, too_fast=1.
//  3. ptch=16'h01FF for 300 vlds.
//     -> integ stops at 130816, never wraps negative; I=2044.
//  4. RUN, pid_reg=0, en_steer=1, ld_cell_diff=12'h080.
//     -> lft_spd=16 rev=0, rght_spd=16 rght_rev=1.
//     en_steer=0 -> both 0.
//  5. pwr_up 0->1 with large error.
//     -> spd tracks ramp_cnt, reaches RUN after 2047 clks.
//     rider_off=1 mid-ramp -> outputs 0, integ 0, IDLE next clk.
//  6. rst_n low mid-RUN.
//     -> all outputs 0 asynchronously; after release, outputs stay 0 until pwr_up ramp.

Source files
------------

// File: rtl/balance_cntrl_pkg.sv
// Shared types, widths and saturation helpers for the balance controller.
package segway_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, RUN} bal_state_t;

  localparam int ERR_W   = 10;
  localparam int DIFF_W  = 7;
  localparam int INTEG_W = 18;
  localparam logic [10:0] SPD_MAX = 11'h7FF;

  // Clamp v to the signed range of a w-bit value (w <= 17).
  function automatic logic signed [17:0] sat_signed(input logic signed [17:0] v, input int w);
    logic signed [17:0] hi, lo;
    hi = 18'((1 << (w - 1)) - 1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [10:0] clip_mag(input logic [16:0] mag, input logic [10:0] lim);
    return (mag > {6'd0, lim}) ? lim : mag[10:0];
  endfunction
endpackage

// File: rtl/balance_cntrl_if.sv
// Pitch/steering inputs and motor drive outputs of the balance controller.
interface balance_cntrl_if;
  logic               vld;
  logic signed [15:0] ptch;
  logic signed [11:0] ld_cell_diff;
  logic               en_steer;
  logic               rider_off;
  logic               pwr_up;
  logic [10:0]        lft_spd;
  logic               lft_rev;
  logic [10:0]        rght_spd;
  logic               rght_rev;
  logic               too_fast;

  modport master (output vld, ptch, ld_cell_diff, en_steer, rider_off, pwr_up,
                  input  lft_spd, lft_rev, rght_spd, rght_rev, too_fast);
  modport slave  (input  vld, ptch, ld_cell_diff, en_steer, rider_off, pwr_up,
                  output lft_spd, lft_rev, rght_spd, rght_rev, too_fast);
endinterface

// File: rtl/balance_cntrl_pid.sv
// PID on saturated pitch error: overflow-frozen integrator, vld-driven D queue, registered sum.
module balance_pid
  import segway_pkg::*;
#(
  parameter int P_COEFF = 12,
  parameter int D_COEFF = 20,
  parameter int D_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic               rider_off,
  input  logic signed [15:0] ptch,
  output logic signed [15:0] pid_reg
);
  localparam logic signed [4:0] P_K = 5'(P_COEFF);
  localparam logic signed [6:0] D_K = 7'(D_COEFF);

  logic signed [ERR_W-1:0]   err_sat, oldest;
  logic signed [14:0]        p_term;
  logic signed [INTEG_W-1:0] integ, integ_sum;
  logic                      ovf;
  logic signed [15:0]        i_term;
  logic [D_DEPTH-1:0][ERR_W-1:0] dq;
  logic signed [10:0]        diff_raw;
  logic signed [DIFF_W-1:0]  diff_sat;
  logic signed [12:0]        d_term;
  logic signed [17:0]        pid_sum;

  assign err_sat = ERR_W'(sat_signed(18'(ptch), ERR_W));
  assign p_term  = 15'(err_sat) * 15'(P_K);

  // Freeze rather than wrap when both operands share a sign the sum lost.
  assign integ_sum = integ + INTEG_W'(err_sat);
  assign ovf       = (integ[INTEG_W-1] == err_sat[ERR_W-1]) && (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
  assign i_term    = 16'(integ >>> 6);

  assign oldest   = $signed(dq[D_DEPTH-1]);
  assign diff_raw = 11'(err_sat) - 11'(oldest);
  assign diff_sat = DIFF_W'(sat_signed(18'(diff_raw), DIFF_W));
  assign d_term   = 13'(diff_sat) * 13'(D_K);

  assign pid_sum = 18'(p_term) + 18'(i_term) + 18'(d_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ   <= '0;
      dq      <= '0;
      pid_reg <= '0;
    end else begin
      if (rider_off)       integ <= '0;
      else if (vld && !ovf) integ <= integ_sum;
      if (vld) begin
        dq[0] <= err_sat;
        for (int i = 1; i < D_DEPTH; i++) dq[i] <= dq[i-1];
        pid_reg <= 16'(sat_signed(pid_sum, 16));
      end
    end
  end
endmodule

// File: rtl/balance_cntrl.sv
// Balance loop top: steering mix, soft-start FSM, sign/magnitude motor drive, too_fast flag.
module balance_cntrl
  import segway_pkg::*;
#(
  parameter int P_COEFF  = 12,
  parameter int D_COEFF  = 20,
  parameter int D_DEPTH  = 2,
  parameter int TOO_FAST = 1536
) (
  input logic           clk,
  input logic           rst_n,
  balance_cntrl_if.slave bus
);
  logic signed [15:0] pid_reg, steer;
  logic signed [16:0] lft_trq, rght_trq;
  logic [16:0]        lft_mag, rght_mag;
  bal_state_t         state, state_nxt;
  logic [10:0]        ramp_cnt, ramp_nxt, limit;
  logic               gate;
  logic [10:0]        lft_spd_q, rght_spd_q;
  logic               lft_rev_q, rght_rev_q, too_fast_q;

  balance_pid #(.P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .D_DEPTH(D_DEPTH)) u_pid (
    .clk(clk), .rst_n(rst_n), .vld(bus.vld), .rider_off(bus.rider_off),
    .ptch(bus.ptch), .pid_reg(pid_reg)
  );

  assign steer    = bus.en_steer ? 16'(bus.ld_cell_diff >>> 3) : '0;
  assign lft_trq  = 17'(pid_reg) + 17'(steer);
  assign rght_trq = 17'(pid_reg) - 17'(steer);
  assign lft_mag  = lft_trq[16]  ? 17'(-lft_trq)  : 17'(lft_trq);
  assign rght_mag = rght_trq[16] ? 17'(-rght_trq) : 17'(rght_trq);

  always_comb begin
    state_nxt = state;
    ramp_nxt  = ramp_cnt;
    case (state)
      IDLE: begin
        ramp_nxt = '0;
        state_nxt = RAMP;
      end
      RAMP: begin
        if (ramp_cnt == SPD_MAX) state_nxt = RUN;
        else                     ramp_nxt  = ramp_cnt + 11'd1;
      end
      RUN:     ;
      default: state_nxt = IDLE;
    endcase
    // rider_off takes priority over pwr_up from every state
    if (!bus.pwr_up || bus.rider_off) begin
      state_nxt = IDLE;
      ramp_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ramp_cnt <= ramp_nxt;
    end
  end

  assign gate  = (state == IDLE) || bus.rider_off || !bus.pwr_up;
  assign limit = (state == RUN) ? SPD_MAX : ramp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || gate) begin
      lft_spd_q  <= '0;
      lft_rev_q  <= 1'b0;
      rght_spd_q <= '0;
      rght_rev_q <= 1'b0;
      too_fast_q <= 1'b0;
    end else begin
      lft_spd_q  <= clip_mag(lft_mag, limit);
      lft_rev_q  <= lft_trq[16];
      rght_spd_q <= clip_mag(rght_mag, limit);
      rght_rev_q <= rght_trq[16];
      too_fast_q <= (lft_mag > 17'(TOO_FAST)) || (rght_mag > 17'(TOO_FAST));
    end
  end

  assign bus.lft_spd  = lft_spd_q;
  assign bus.lft_rev  = lft_rev_q;
  assign bus.rght_spd = rght_spd_q;
  assign bus.rght_rev = rght_rev_q;
  assign bus.too_fast = too_fast_q;
endmodule

// File: tb/tb_balance_cntrl.sv
// Directed plus randomized bench for balance_cntrl against an arithmetic reference model.
module tb_balance_cntrl;
  localparam int D_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  balance_cntrl_if bus();

  balance_cntrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_integ = 0;
  int m_pid   = 0;
  int m_q [D_DEPTH];
  int e_lspd, e_rspd, e_lrev, e_rrev, e_tf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int lo, input int hi);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    m_integ = 0;
    m_pid   = 0;
    for (int i = 0; i < D_DEPTH; i++) m_q[i] = 0;
  endfunction

  function automatic void model_vld(input logic [15:0] p);
    int err, pid, s;
    err = sat(int'($signed(p)), -512, 511);
    pid = sat(err * 12 + (m_integ >>> 6) + sat(err - m_q[D_DEPTH-1], -64, 63) * 20, -32768, 32767);
    s = m_integ + err;
    if (s <= 131071 && s >= -131072) m_integ = s;
    for (int i = D_DEPTH - 1; i > 0; i--) m_q[i] = m_q[i-1];
    m_q[0] = err;
    m_pid = pid;
  endfunction

  // expected RUN-state outputs after the coming edge
  function automatic void model_out(input logic [11:0] l, input bit en);
    int st, lt, rt;
    st = en ? (int'($signed(l)) >>> 3) : 0;
    lt = m_pid + st;
    rt = m_pid - st;
    e_lspd = (iabs(lt) > 2047) ? 2047 : iabs(lt);
    e_rspd = (iabs(rt) > 2047) ? 2047 : iabs(rt);
    e_lrev = (lt < 0) ? 1 : 0;
    e_rrev = (rt < 0) ? 1 : 0;
    e_tf   = (iabs(lt) > 1536 || iabs(rt) > 1536) ? 1 : 0;
  endfunction

  task automatic step(input bit v, input logic [15:0] p, input logic [11:0] l, input bit en);
    bus.vld = v; bus.ptch = p; bus.ld_cell_diff = l; bus.en_steer = en;
    model_out(l, en);
    if (v) model_vld(p);
    @(posedge clk); @(negedge clk);
    chk("lft_spd",  32'(bus.lft_spd),  32'(e_lspd));
    chk("lft_rev",  32'(bus.lft_rev),  32'(e_lrev));
    chk("rght_spd", 32'(bus.rght_spd), 32'(e_rspd));
    chk("rght_rev", 32'(bus.rght_rev), 32'(e_rrev));
    chk("too_fast", 32'(bus.too_fast), 32'(e_tf));
    bus.vld = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_lspd"}, 32'(bus.lft_spd), 0);
    chk({tag, "_lrev"}, 32'(bus.lft_rev), 0);
    chk({tag, "_rspd"}, 32'(bus.rght_spd), 0);
    chk({tag, "_rrev"}, 32'(bus.rght_rev), 0);
    chk({tag, "_tf"},   32'(bus.too_fast), 0);
  endtask

  // Soft start from IDLE with positive pitch: speed follows elapsed ramp clocks.
  task automatic ramp(input int n, input int nv);
    int exp_spd;
    bus.ptch = 16'h01FF; bus.en_steer = 1'b0; bus.ld_cell_diff = '0;
    for (int k = 0; k <= n; k++) begin
      bus.vld = (k < nv);
      if (k < nv) model_vld(16'h01FF);
      @(posedge clk); @(negedge clk);
      exp_spd = (k == 0) ? 0 : ((k - 1 > 2047) ? 2047 : k - 1);
      chk("ramp_lspd", 32'(bus.lft_spd),  32'(exp_spd));
      chk("ramp_rspd", 32'(bus.rght_spd), 32'(exp_spd));
      chk("ramp_lrev", 32'(bus.lft_rev), 0);
      chk("ramp_tf",   32'(bus.too_fast), (k == 0) ? 0 : 1);
    end
    bus.vld = 1'b0;
  endtask

  initial begin
    int pv;
    model_reset();
    bus.vld = 0; bus.ptch = '0; bus.ld_cell_diff = '0; bus.en_steer = 0;
    bus.rider_off = 0; bus.pwr_up = 0;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    rst_n = 1'b1;

    // fresh ramp with no pitch samples: pid stays 0
    bus.pwr_up = 1'b1;
    repeat (2060) @(negedge clk);
    outs_zero("ramp0");

    // steering only on zero pid
    step(0, 16'h0000, 12'h080, 1);
    chk("steer_lspd", 32'(bus.lft_spd), 16);
    chk("steer_rrev", 32'(bus.rght_rev), 1);
    step(0, 16'h0000, 12'h080, 0);
    chk("nosteer_lspd", 32'(bus.lft_spd), 0);

    // single small sample: 192 + 0 + 320 two clocks later
    step(1, 16'h0010, 12'h000, 0);
    step(0, 16'h0010, 12'h000, 0);
    chk("t1_lspd", 32'(bus.lft_spd), 512);
    chk("t1_rspd", 32'(bus.rght_spd), 512);

    // full negative pitch
    repeat (3) step(1, 16'h8000, 12'h000, 0);
    chk("t2_lspd", 32'(bus.lft_spd), 2047);
    chk("t2_lrev", 32'(bus.lft_rev), 1);
    chk("t2_tf",   32'(bus.too_fast), 1);

    // randomized RUN traffic
    for (int i = 0; i < 200; i++) begin
      pv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1200)) - 600;
      step(bit'($urandom_range(0, 1)), 16'(pv), 12'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)));
    end

    // rider steps off: zero outputs and integrator next clock
    bus.rider_off = 1'b1;
    m_integ = 0;
    @(posedge clk); @(negedge clk);
    outs_zero("roff");
    chk("roff_integ", 32'(dut.u_pid.integ), 0);
    bus.rider_off = 1'b0;

    // re-ramp with 300 max-positive samples: integrator freezes without wrapping
    ramp(2060, 300);
    chk("integ_sat", 32'(dut.u_pid.integ), 130816);
    step(1, 16'h0000, 12'h000, 0);
    step(1, 16'h0000, 12'h000, 0);
    chk("t3_lspd", 32'(bus.lft_spd), 764);
    step(0, 16'h0000, 12'h000, 0);

    // asynchronous reset mid-RUN
    #2 rst_n = 1'b0;
    #1 outs_zero("async_rst");
    model_reset();
    @(negedge clk);
    bus.pwr_up = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.vld = 1'b1; bus.ptch = 16'h01FF;
      model_vld(16'h01FF);
      @(posedge clk); @(negedge clk);
      outs_zero("idle");
    end
    bus.vld = 1'b0;
    bus.pwr_up = 1'b1;
    ramp(30, 30);

    // rider_off during the ramp
    bus.rider_off = 1'b1;
    @(posedge clk); @(negedge clk);
    outs_zero("roff_ramp");
    chk("roff_ramp_integ", 32'(dut.u_pid.integ), 0);
    @(posedge clk); @(negedge clk);
    outs_zero("roff_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
